alu_stim_range_gen: RTL and testbench
=====================================

// Module: alu_stim_range_gen
// PURPOSE
//  Synthesisable, parametrised stimulus generator for the multi-cycle ALU input channel.
//  Emits a programmed number of operand/opcode transactions over a valid/ready handshake.
//  Operands are drawn as LFSR-random values over the full range, or constrained to
//  per-operand [min,max] windows, or as deterministic corner sequences.
//  Sits between the test controller and the ALU input interface; replaces per-test blueprint tweaking.
// PARAMETERS
//  OPERAND_MAX_DATA_WIDTH  8             operand width W, 2..16
//  OPCODE_WIDTH            3             opcode width OPW, 1..8
//  CNT_WIDTH               16            width of transaction count / tx_count
//  LFSR_SEED               32'h1ACE_B00C LFSR reset seed; must be nonzero (0 is replaced by 1)
// PORTS
//  clk       in   1     clock
//  rst       in   1     synchronous reset, active-high
//  start     in   1     1-cycle pulse; latches config, begins run (ignored while busy)
//  mode      in   2     0 FULL, 1 RANGE, 2 CORNER, 3 reserved (= RANGE)
//  num_tx    in   CNT   transactions to emit
//  a_min/a_max, b_min/b_max  in  W  operand windows (inclusive)
//  op_fixed  in   OPW   opcode used when op_rand=0
//  op_rand   in   1     1: opcode from LFSR
//  out_valid out  1     transaction valid
//  out_ready in   1     downstream accept
//  out_a/out_b out W    operands
//  out_op    out  OPW   opcode
//  busy      out  1     run in progress (LOAD or GEN)
//  done      out  1     1-cycle pulse at end of run
//  tx_count  out  CNT   transactions accepted in current/last run
// BEHAVIOUR
//  - Reset: state IDLE; out_valid, busy, done = 0; out_a/out_b/out_op = 0; tx_count = 0; LFSR = seed.
//  - FSM: IDLE -start-> LOAD; LOAD -> GEN (num_tx>0) or DONE (num_tx=0); GEN -last accept-> DONE; DONE -> IDLE.
//  - LOAD: latch mode, num_tx, windows, op_fixed, op_rand; clear tx_count; compute first tx.
//    If min>max for an operand, the bounds are swapped.
//  - Latency: start at cycle t -> out_valid=1 at t+2. busy=1 from t+1 until DONE. done=1 for one cycle in DONE.
//  - Handshake: accept = out_valid & out_ready. While out_valid & !out_ready, out_a/b/op are held stable.
//    On accept: tx_count++; next tx registered the same edge; out_valid stays high (1 tx/cycle throughput).
//    On the last accept, out_valid drops the next cycle.
//  - LFSR: 32-bit Galois, taps 0x80200003. Advances only in LOAD and on accept, so sequences are
//    reproducible regardless of backpressure.
//  - Draws: ra = lfsr[W-1:0]; rb = lfsr[16+W-1:16].
//    Random opcode = lfsr[OPW-1:0] ^ lfsr[16+OPW-1:16].
//  - FULL: a = ra, b = rb.
//  - RANGE, per operand: span = max-min (W bits); mask = smallest 2^k-1 >= span; off = r & mask;
//    if off > span then off = off - span - 1; value = min + off. Result always lies in [min,max].
//    min==max yields the constant value.
//  - CORNER: set C = {min, min+1, max-1, max}, each element clamped to [min,max].
//    a = C[i mod 4], b = C[(i/4) mod 4], where i = tx_count.
//  - Arithmetic: unsigned, no wrap. Sums are computed at W+1 bits; the result is <= max, so it fits in W.
//  - start during LOAD/GEN/DONE is ignored. rst mid-run aborts immediately: out_valid=0, and done is not pulsed.
//  - tx_count holds its final value after the run until the next LOAD.
// CONFIGURATION
//  ALU_STIM_CORNER_EN defined: mode 2 = CORNER, as above.
//  ALU_STIM_CORNER_EN undefined: CORNER logic is not built and mode 2 behaves as RANGE.
// TESTING (W=8, OPW=3)
//  1 Reset: assert rst 3 cycles -> out_valid=0, busy=0, done=0, tx_count=0, outputs 0.
//  2 RANGE, a_min=a_max=b_min=b_max=255, num_tx=10, ready=1 -> 10 tx a=b=255 on consecutive cycles;
//    done one cycle after the 10th accept; tx_count=10.
//  3 RANGE, a_min=200, a_max=100, b_min=0, b_max=3, num_tx=1000 -> every a in [100,200], b in [0,3];
//    every value of b appears.
//  4 Backpressure: ready=0 for 5 cycles mid-run -> out_valid high and out_a/b/op unchanged;
//    the sequence after release is identical to a run with ready=1.
//  5 num_tx=0 -> done pulses at t+2, out_valid never 1; start during GEN has no effect;
//    rst at the 3rd tx -> IDLE next cycle, no done.
//  6 CORNER (macro on), a=[10,20], b=[0,255], num_tx=16 -> (10,0) (11,0) (19,0) (20,0) (10,1) ... (20,255);
//    with macro off, same config -> all values within windows.

Source files
------------

// File: rtl/alu_stim_range_gen_if.sv
// ALU input channel: valid/ready handshake carrying two operands and an opcode.
interface alu_stim_range_gen_if #(
  parameter int W   = 8,
  parameter int OPW = 3
);
  logic           out_valid;
  logic           out_ready;
  logic [W-1:0]   out_a;
  logic [W-1:0]   out_b;
  logic [OPW-1:0] out_op;

  modport master (output out_valid, out_a, out_b, out_op, input out_ready);
  modport slave  (input out_valid, out_a, out_b, out_op, output out_ready);
endinterface

// File: rtl/alu_stim_range_gen.sv
// alu_stim_range_gen: programmable operand/opcode stimulus source for the ALU input channel.
// Define ALU_STIM_CORNER_EN to build the CORNER sequence (mode 2); otherwise mode 2 behaves as RANGE.
module alu_stim_range_gen #(
  parameter int          OPERAND_MAX_DATA_WIDTH = 8,
  parameter int          OPCODE_WIDTH           = 3,
  parameter int          CNT_WIDTH              = 16,
  parameter logic [31:0] LFSR_SEED              = 32'h1ACE_B00C
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              start,
  input  logic [1:0]                        mode,
  input  logic [CNT_WIDTH-1:0]              num_tx,
  input  logic [OPERAND_MAX_DATA_WIDTH-1:0] a_min,
  input  logic [OPERAND_MAX_DATA_WIDTH-1:0] a_max,
  input  logic [OPERAND_MAX_DATA_WIDTH-1:0] b_min,
  input  logic [OPERAND_MAX_DATA_WIDTH-1:0] b_max,
  input  logic [OPCODE_WIDTH-1:0]           op_fixed,
  input  logic                              op_rand,
  alu_stim_range_gen_if.master              out_if,
  output logic                              busy,
  output logic                              done,
  output logic [CNT_WIDTH-1:0]              tx_count
);
  localparam int          W      = OPERAND_MAX_DATA_WIDTH;
  localparam int          OPW    = OPCODE_WIDTH;
  localparam logic [31:0] SEED   = (LFSR_SEED == 32'h0) ? 32'h1 : LFSR_SEED;
  localparam logic [1:0]  M_FULL = 2'd0;

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_GEN, S_DONE} state_t;
  state_t state, state_nxt;

  logic [1:0]           mode_q;
  logic [CNT_WIDTH-1:0] num_q;
  logic [W-1:0]         a_lo, a_hi, b_lo, b_hi;
  logic [OPW-1:0]       opf_q;
  logic                 opr_q;
  logic [31:0]          lfsr, lfsr_nxt;
  logic                 valid_q;
  logic [W-1:0]         a_q, b_q, nx_a, nx_b;
  logic [OPW-1:0]       op_q, nx_op;
  logic                 accept, last;

  function automatic logic [31:0] lfsr_step(input logic [31:0] s);
    return {1'b0, s[31:1]} ^ (s[0] ? 32'h8020_0003 : 32'h0);
  endfunction

  // Fold the masked draw back into [0,span]; lo+off never exceeds hi, so W bits suffice.
  function automatic logic [W-1:0] range_draw(input logic [W-1:0] lo, input logic [W-1:0] hi,
                                              input logic [W-1:0] r);
    logic [W-1:0] span, mask, off;
    logic [W:0]   sum;
    span = hi - lo;
    mask = span;
    for (int k = 1; k < W; k++) mask = mask | (mask >> k);
    off = r & mask;
    if (off > span) off = off - span - W'(1);
    sum = {1'b0, lo} + {1'b0, off};
    return sum[W-1:0];
  endfunction

`ifdef ALU_STIM_CORNER_EN
  localparam logic [1:0] M_CORNER = 2'd2;
  logic [CNT_WIDTH-1:0] idx;

  function automatic logic [W-1:0] corner_pick(input logic [W-1:0] lo, input logic [W-1:0] hi,
                                               input logic [1:0] sel);
    case (sel)
      2'd0:    return lo;
      2'd1:    return (lo < hi) ? lo + W'(1) : hi;
      2'd2:    return (hi > lo) ? hi - W'(1) : lo;
      default: return hi;
    endcase
  endfunction

  assign idx = (state == S_LOAD) ? '0 : tx_count + CNT_WIDTH'(1);
`endif

  // Next transaction is always drawn from the advanced LFSR value.
  always_comb begin
    lfsr_nxt = lfsr_step(lfsr);
    nx_a     = range_draw(a_lo, a_hi, lfsr_nxt[W-1:0]);
    nx_b     = range_draw(b_lo, b_hi, lfsr_nxt[16+W-1:16]);
    if (mode_q == M_FULL) begin
      nx_a = lfsr_nxt[W-1:0];
      nx_b = lfsr_nxt[16+W-1:16];
    end
`ifdef ALU_STIM_CORNER_EN
    else if (mode_q == M_CORNER) begin
      nx_a = corner_pick(a_lo, a_hi, idx[1:0]);
      nx_b = corner_pick(b_lo, b_hi, idx[3:2]);
    end
`endif
    nx_op = opr_q ? (lfsr_nxt[OPW-1:0] ^ lfsr_nxt[16+OPW-1:16]) : opf_q;
  end

  assign accept = valid_q & out_if.out_ready;
  assign last   = accept & (tx_count + CNT_WIDTH'(1) == num_q);

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      S_IDLE: if (start) state_nxt = S_LOAD;
      S_LOAD: begin
        busy      = 1'b1;
        state_nxt = (num_q == '0) ? S_DONE : S_GEN;
      end
      S_GEN: begin
        busy = 1'b1;
        if (last) state_nxt = S_DONE;
      end
      default: begin
        done      = 1'b1;
        state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mode_q   <= '0;
      num_q    <= '0;
      a_lo     <= '0;
      a_hi     <= '0;
      b_lo     <= '0;
      b_hi     <= '0;
      opf_q    <= '0;
      opr_q    <= 1'b0;
      lfsr     <= SEED;
      valid_q  <= 1'b0;
      a_q      <= '0;
      b_q      <= '0;
      op_q     <= '0;
      tx_count <= '0;
    end else begin
      case (state)
        S_IDLE: if (start) begin
          mode_q <= mode;
          num_q  <= num_tx;
          a_lo   <= (a_min > a_max) ? a_max : a_min;
          a_hi   <= (a_min > a_max) ? a_min : a_max;
          b_lo   <= (b_min > b_max) ? b_max : b_min;
          b_hi   <= (b_min > b_max) ? b_min : b_max;
          opf_q  <= op_fixed;
          opr_q  <= op_rand;
        end
        S_LOAD: begin
          lfsr     <= lfsr_nxt;
          tx_count <= '0;
          a_q      <= nx_a;
          b_q      <= nx_b;
          op_q     <= nx_op;
          valid_q  <= (num_q != '0);
        end
        S_GEN: if (accept) begin
          lfsr     <= lfsr_nxt;
          tx_count <= tx_count + CNT_WIDTH'(1);
          a_q      <= nx_a;
          b_q      <= nx_b;
          op_q     <= nx_op;
          valid_q  <= ~last;
        end
        default: ;
      endcase
    end
  end

  assign out_if.out_valid = valid_q;
  assign out_if.out_a     = a_q;
  assign out_if.out_b     = b_q;
  assign out_if.out_op    = op_q;
endmodule

// File: tb/tb_alu_stim_range_gen.sv
// Self-checking bench for alu_stim_range_gen (W=8, OPW=3) against a behavioural operand model.
module tb_alu_stim_range_gen;
  localparam logic [31:0] SEED = 32'h1ACE_B00C;

  logic        clk = 1'b0;
  logic        rst, start, op_rand, busy, done;
  logic [1:0]  mode;
  logic [15:0] num_tx, tx_count;
  logic [7:0]  a_min, a_max, b_min, b_max;
  logic [2:0]  op_fixed;

  alu_stim_range_gen_if #(.W(8), .OPW(3)) bus ();

  alu_stim_range_gen #(
    .OPERAND_MAX_DATA_WIDTH(8), .OPCODE_WIDTH(3), .CNT_WIDTH(16), .LFSR_SEED(SEED)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .mode(mode), .num_tx(num_tx),
    .a_min(a_min), .a_max(a_max), .b_min(b_min), .b_max(b_max),
    .op_fixed(op_fixed), .op_rand(op_rand), .out_if(bus),
    .busy(busy), .done(done), .tx_count(tx_count)
  );

  always #5 clk = ~clk;

  int          n_cmp = 0;
  int          n_bad = 0;
  logic [31:0] m_lfsr;
  int          qa[$], qb[$], qop[$];
  bit [255:0]  b_seen;

  // ---------------- reference model ----------------
  function automatic logic [31:0] m_step(input logic [31:0] s);
    return s[0] ? ((s >> 1) ^ 32'h8020_0003) : (s >> 1);
  endfunction

  function automatic int m_range(input int mn, input int mx, input int r);
    int lo, hi, span, mask, off;
    lo = (mn < mx) ? mn : mx;
    hi = (mn < mx) ? mx : mn;
    span = hi - lo;
    mask = 0;
    while (mask < span) mask = mask * 2 + 1;
    off = r & mask;
    if (off > span) off = off - span - 1;
    return lo + off;
  endfunction

  function automatic int m_corner(input int mn, input int mx, input int sel);
    int lo, hi;
    int c[4];
    lo = (mn < mx) ? mn : mx;
    hi = (mn < mx) ? mx : mn;
    c[0] = lo;
    c[1] = (lo + 1 > hi) ? hi : lo + 1;
    c[2] = (hi - 1 < lo) ? lo : hi - 1;
    c[3] = hi;
    return c[sel];
  endfunction

  function automatic void m_tx(input logic [31:0] s, input int i, output int a, output int b,
                               output int op);
    int ra, rb;
    ra = int'(s[7:0]);
    rb = int'(s[23:16]);
    op = op_rand ? int'(s[2:0] ^ s[18:16]) : int'(op_fixed);
    if (mode == 2'd0) begin
      a = ra;
      b = rb;
    end
`ifdef ALU_STIM_CORNER_EN
    else if (mode == 2'd2) begin
      a = m_corner(int'(a_min), int'(a_max), i % 4);
      b = m_corner(int'(b_min), int'(b_max), (i / 4) % 4);
    end
`endif
    else begin
      a = m_range(int'(a_min), int'(a_max), ra);
      b = m_range(int'(b_min), int'(b_max), rb);
    end
  endfunction

  // rmode: 0 ready always, 1 random ready, 2 five-cycle stall at the 4th tx.
  task automatic do_run(input int rmode, input bit poke, input int abort_at);
    logic [31:0] cur;
    int          k, n, ea, eb, eop, stall, budget;
    bit          held, poked;
    logic [7:0]  ha, hb;
    logic [2:0]  hop;
    n = int'(num_tx); k = 0; stall = 0; held = 0; poked = 0;
    qa.delete(); qb.delete(); qop.delete();
    cur = m_step(m_lfsr);
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    n_cmp++;
    if ({busy, bus.out_valid, done} !== 3'b100) begin
      n_bad++; $display("FAIL load_state busy/valid/done got %b want 100", {busy, bus.out_valid, done});
    end
    budget = 10 * n + 50;
    @(negedge clk);
    while (k < n && budget > 0) begin
      budget--;
      if (abort_at == k) begin
        start = 1'b0; rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        n_cmp++;
        if ({bus.out_valid, busy, done} !== 3'b000) begin
          n_bad++; $display("FAIL abort_state valid/busy/done got %b want 000", {bus.out_valid, busy, done});
        end
        repeat (4) begin
          @(negedge clk);
          n_cmp++;
          if ({busy, done} !== 2'b00) begin
            n_bad++; $display("FAIL abort_no_done busy/done got %b want 00", {busy, done});
          end
        end
        m_lfsr = SEED;
        return;
      end
      if (poke && k == 2 && !poked) begin start = 1'b1; poked = 1; end
      else start = 1'b0;
      if (rmode == 1) bus.out_ready = ($urandom_range(0, 3) != 0);
      else if (rmode == 2 && k == 3 && stall < 5) begin bus.out_ready = 1'b0; stall++; end
      else bus.out_ready = 1'b1;
      n_cmp++;
      if (bus.out_valid !== 1'b1) begin
        n_bad++; $display("FAIL gen_valid tx %0d got %b want 1", k, bus.out_valid);
      end
      if (held) begin
        n_cmp++;
        if ({bus.out_a, bus.out_b, bus.out_op} !== {ha, hb, hop}) begin
          n_bad++; $display("FAIL hold tx %0d got %0d/%0d/%0d want %0d/%0d/%0d", k,
                            bus.out_a, bus.out_b, bus.out_op, ha, hb, hop);
        end
      end
      held = 0;
      if (bus.out_ready) begin
        m_tx(cur, k, ea, eb, eop);
        n_cmp++;
        if (bus.out_a !== 8'(ea) || bus.out_b !== 8'(eb) || bus.out_op !== 3'(eop)) begin
          n_bad++; $display("FAIL tx %0d got a=%0d b=%0d op=%0d want a=%0d b=%0d op=%0d", k,
                            bus.out_a, bus.out_b, bus.out_op, ea, eb, eop);
        end
        qa.push_back(int'(bus.out_a)); qb.push_back(int'(bus.out_b)); qop.push_back(int'(bus.out_op));
        b_seen[bus.out_b] = 1'b1;
        cur = m_step(cur);
        k++;
      end else begin
        held = 1; ha = bus.out_a; hb = bus.out_b; hop = bus.out_op;
      end
      @(negedge clk);
    end
    start = 1'b0;
    if (k < n) begin
      n_cmp++; n_bad++; $display("FAIL timeout accepted %0d want %0d", k, n);
    end
    n_cmp++;
    if ({bus.out_valid, busy, done} !== 3'b001 || tx_count !== 16'(n)) begin
      n_bad++; $display("FAIL done_state valid/busy/done=%b tx_count=%0d want 001 / %0d",
                        {bus.out_valid, busy, done}, tx_count, n);
    end
    m_lfsr = cur;
    @(negedge clk);
    n_cmp++;
    if ({busy, done} !== 2'b00 || tx_count !== 16'(n)) begin
      n_bad++; $display("FAIL after_done busy/done=%b tx_count=%0d want 00 / %0d", {busy, done}, tx_count, n);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    m_lfsr = SEED;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({bus.out_valid, busy, done} !== 3'b000 || tx_count !== 16'd0) begin
      n_bad++; $display("FAIL reset_ctrl valid/busy/done=%b tx_count=%0d want 000 / 0",
                        {bus.out_valid, busy, done}, tx_count);
    end
    n_cmp++;
    if ({bus.out_a, bus.out_b, bus.out_op} !== 19'd0) begin
      n_bad++; $display("FAIL reset_data a=%0d b=%0d op=%0d want 0", bus.out_a, bus.out_b, bus.out_op);
    end
    rst = 1'b0;
    m_lfsr = SEED;
    @(negedge clk);
    n_cmp++;
    if ({bus.out_valid, busy, done} !== 3'b000) begin
      n_bad++; $display("FAIL idle_after_reset got %b want 000", {bus.out_valid, busy, done});
    end
  endtask

  task automatic test_const_range();
    mode = 2'd1; a_min = 8'd255; a_max = 8'd255; b_min = 8'd255; b_max = 8'd255;
    num_tx = 16'd10; op_rand = 1'b0; op_fixed = 3'd5;
    do_run(0, 0, -1);
    n_cmp++;
    if (qa.size() != 10) begin n_bad++; $display("FAIL const_count got %0d want 10", qa.size()); end
    foreach (qa[i]) begin
      n_cmp++;
      if (qa[i] != 255 || qb[i] != 255 || qop[i] != 5) begin
        n_bad++; $display("FAIL const_val tx %0d got %0d/%0d/%0d want 255/255/5", i, qa[i], qb[i], qop[i]);
      end
    end
  endtask

  task automatic test_range_swap();
    int bad;
    mode = 2'd1; a_min = 8'd200; a_max = 8'd100; b_min = 8'd0; b_max = 8'd3;
    num_tx = 16'd1000; op_rand = 1'b1; b_seen = '0;
    do_run(1, 0, -1);
    bad = 0;
    foreach (qa[i]) if (qa[i] < 100 || qa[i] > 200 || qb[i] > 3) bad++;
    n_cmp++;
    if (bad != 0) begin n_bad++; $display("FAIL range_window got %0d out-of-window want 0", bad); end
    n_cmp++;
    if (b_seen[3:0] !== 4'hF) begin n_bad++; $display("FAIL range_b_cover got %b want 1111", b_seen[3:0]); end
  endtask

  task automatic test_backpressure();
    int ra[$], rb[$], rop[$];
    mode = 2'd1; a_min = 8'($urandom); a_max = 8'($urandom); b_min = 8'($urandom); b_max = 8'($urandom);
    num_tx = 16'd12; op_rand = 1'b1;
    do_reset();
    do_run(0, 0, -1);
    ra = qa; rb = qb; rop = qop;
    do_reset();
    do_run(2, 0, -1);
    n_cmp++;
    if (qa != ra || qb != rb || qop != rop) begin
      n_bad++; $display("FAIL bp_repeat got %0d tx differing from ready-high run want identical", qa.size());
    end
  endtask

  task automatic test_full_random();
    mode = 2'd0; num_tx = 16'd40; op_rand = 1'b1;
    do_run(1, 0, -1);
    mode = 2'd3; a_min = 8'($urandom); a_max = 8'($urandom); b_min = 8'd7; b_max = 8'd7;
    num_tx = 16'd20; op_rand = 1'b0; op_fixed = 3'($urandom);
    do_run(1, 0, -1);
  endtask

  task automatic test_zero_tx();
    mode = 2'd1; num_tx = 16'd0;
    do_run(0, 0, -1);
  endtask

  task automatic test_start_during_gen();
    mode = 2'd0; num_tx = 16'd8; op_rand = 1'b1;
    do_run(0, 1, -1);
  endtask

  task automatic test_abort();
    mode = 2'd1; a_min = 8'd5; a_max = 8'd60; num_tx = 16'd20;
    do_run(0, 0, 2);
    num_tx = 16'd6;
    do_run(0, 0, -1);
  endtask

  task automatic test_corner();
    mode = 2'd2; a_min = 8'd10; a_max = 8'd20; b_min = 8'd0; b_max = 8'd255;
    num_tx = 16'd16; op_rand = 1'b0; op_fixed = 3'd2;
    do_run(0, 0, -1);
`ifdef ALU_STIM_CORNER_EN
    n_cmp++;
    if (qa.size() != 16 || qa[0] != 10 || qa[1] != 11 || qa[2] != 19 || qa[3] != 20 ||
        qb[0] != 0 || qb[4] != 1 || qb[8] != 254 || qb[15] != 255 || qa[15] != 20) begin
      n_bad++; $display("FAIL corner_seq got size %0d first (%0d,%0d) want 16, (10,0) ... (20,255)",
                        qa.size(), qa.size() > 0 ? qa[0] : -1, qb.size() > 0 ? qb[0] : -1);
    end
`else
    n_cmp++;
    if (qa.size() != 16 || qa.min() [0] < 10 || qa.max() [0] > 20) begin
      n_bad++; $display("FAIL corner_off_window got size %0d want 16 values in [10,20]", qa.size());
    end
`endif
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; mode = 2'd0; num_tx = '0; a_min = '0; a_max = '0; b_min = '0; b_max = '0;
    op_fixed = '0; op_rand = 1'b0; bus.out_ready = 1'b1;
    test_reset();
    test_const_range();
    test_range_swap();
    test_backpressure();
    test_full_random();
    test_zero_tx();
    test_start_during_gen();
    test_abort();
    test_corner();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog simulation did not finish in time");
    $fatal(1, "watchdog");
  end
endmodule
